// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
package seg7_pkg;

  // All segments off on a common-anode display (active-low segments).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low hex glyphs, bit6 = a ... bit0 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0001100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Bits needed for a counter over 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Datapath-side and pin-side signals of the scan driver.
// load is a single-cycle capture strobe with no ready: whenever load is high
// at a rising edge the driver takes value unconditionally, so there is no
// back-pressure and no transaction is ever stalled.
interface hex_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    mode;
  logic [6:0]              out0;
  logic [NUM_DIGITS-1:0]   enable;

  modport master (output value, load, mode, input out0, enable);
  modport slave  (input value, load, mode, output out0, enable);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure table lookup.
  always_comb begin
    seg = seg_decode(nib);
  end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with hex counter
// mode and optional leading-zero blanking. Outputs are one register stage
// behind the digit index and display register.
module hex_display_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int TICK_DIV      = 50000000,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst,
  hex_display_scan_if.slave bus
);

  localparam int W      = 4 * NUM_DIGITS;
  localparam int TICK_W = cnt_width(TICK_DIV);
  localparam int SCAN_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W  = cnt_width(NUM_DIGITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [W-1:0]          disp;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic [SCAN_W-1:0]     scan_cnt;
  logic                  scan_last;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] en_sel;
  logic                  blank;
  logic [6:0]            seg;

  assign tick      = (tick_cnt == TICK_LAST);
  assign scan_last = (scan_cnt == SCAN_LAST);

  // Free-running counter-mode prescaler; runs regardless of mode.
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Refresh prescaler and digit index; index steps once per refresh period.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_last) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // Display register: load beats increment, so a tick landing on a load is dropped.
  always_ff @(posedge clk) begin
    if (rst)                  disp <= '0;
    else if (bus.load)        disp <= bus.value;
    else if (bus.mode && tick) disp <= disp + W'(1);
  end

  // upper_zero[i]: nibble i and every more-significant nibble are zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((disp >> (4 * i)) == '0);
    end
  end

  // Select the current digit's nibble, its enable pattern and blanking.
  always_comb begin
    nibble = '0;
    en_sel = '1;
    blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        nibble    = disp[4*i +: 4];
        en_sel[i] = 1'b0;
        blank     = (BLANK_LEADING != 0) && (i != 0) && upper_zero[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib (nibble),
    .seg (seg)
  );

  // Pin registers: a blank digit turns off both segments and all anodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out0   <= SEG_BLANK;
      bus.enable <= '1;
    end else begin
      bus.out0   <= blank ? SEG_BLANK : seg;
      bus.enable <= blank ? '1 : en_sel;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: a 4-digit instance (refresh 3, tick 2,
// blanking on) and a 2-digit instance (refresh 1, blanking off).
module tb_hex_display_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_display_scan_if #(.NUM_DIGITS(4)) a_if ();
  hex_display_scan_if #(.NUM_DIGITS(2)) b_if ();

  hex_display_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(3), .TICK_DIV(2), .BLANK_LEADING(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  hex_display_scan #(
    .NUM_DIGITS(2), .REFRESH_DIV(1), .TICK_DIV(4), .BLANK_LEADING(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [8:0]  exp_b_q[$];

  logic [6:0]  dec_tab [16];
  logic [15:0] m_disp;
  int          k;

  initial begin
    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  // Expected {out0, enable} of the 4-digit instance showing digit d of dv.
  function automatic logic [10:0] expect_a(input int d, input logic [15:0] dv);
    logic [3:0] nib;
    logic [3:0] en;
    logic       blk;
    nib = dv[d*4 +: 4];
    blk = (d > 0) && ((dv >> (4 * d)) == 16'h0);
    en  = 4'b0001 << d;
    if (blk) return {7'b1111111, 4'b1111};
    return {dec_tab[nib], ~en};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock with prediction ----------------
  task automatic step();
    logic        r, l, m;
    logic [15:0] v, pre;
    logic [10:0] ea, ga;
    logic [8:0]  eb, gb;
    int          d;
    r   = rst;
    l   = a_if.load;
    m   = a_if.mode;
    v   = a_if.value;
    pre = m_disp;
    if (r) k = 0; else k++;
    if (r) begin
      exp_q.push_back({7'b1111111, 4'b1111});
      exp_b_q.push_back({7'b1111111, 2'b11});
    end else begin
      d = ((k - 1) / 3) % 4;
      exp_q.push_back(expect_a(d, pre));
      exp_b_q.push_back({7'b0000001, (((k - 1) % 2) == 0) ? 2'b10 : 2'b01});
    end
    if (r)                      m_disp = 16'h0;
    else if (l)                 m_disp = v;
    else if (m && (k % 2 == 0)) m_disp = pre + 16'h1;
    @(posedge clk);
    #1;
    ga = {a_if.out0, a_if.enable};
    ea = exp_q.pop_front();
    checks++;
    assert (ga === ea) else begin
      failures++;
      $error("FAIL scan_a k=%0d got=%h exp=%h", k, ga, ea);
    end
    gb = {b_if.out0, b_if.enable};
    eb = exp_b_q.pop_front();
    checks++;
    assert (gb === eb) else begin
      failures++;
      $error("FAIL scan_b k=%0d got=%h exp=%h", k, gb, eb);
    end
  endtask

  task automatic load_a(input logic [15:0] v);
    a_if.value = v;
    a_if.load  = 1'b1;
    step();
    a_if.load  = 1'b0;
  endtask

  // Step until the 4-digit instance is presenting digit d; bounded.
  task automatic wait_digit(input int d);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      step();
      if (k > 0 && ((k - 1) / 3) % 4 == d) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL wait_digit got=timeout exp=digit%0d", d);
    end
  endtask

  // Step until the next edge is a tick edge of the 4-digit instance.
  task automatic align_tick();
    for (int n = 0; n < 4 && (k % 2) != 1; n++) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    m_disp     = 16'h0;
    k          = 0;
    a_if.value = 16'h0;
    a_if.load  = 1'b0;
    a_if.mode  = 1'b0;
    b_if.value = 8'h0;
    b_if.load  = 1'b0;
    b_if.mode  = 1'b0;

    // reset values
    rst = 1'b1;
    step();
    step();
    check("reset_a", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});
    check("reset_b", {b_if.out0, b_if.enable}, {7'b1111111, 2'b11});
    rst = 1'b0;

    // first cycle after reset: digit 0 of zero
    step();
    check("first_digit0", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    check("b_alt0", {7'h0, b_if.enable}, {7'h0, 2'b10});
    step();
    check("b_alt1", {7'h0, b_if.enable}, {7'h0, 2'b01});
    for (int n = 0; n < 4; n++) step();

    // 0x12AF: F, A, 2, 1 on digits 0..3
    load_a(16'h12AF);
    wait_digit(0);
    check("12af_d0", {a_if.out0, a_if.enable}, {7'b0111000, 4'b1110});
    wait_digit(1);
    check("12af_d1", {a_if.out0, a_if.enable}, {7'b0001000, 4'b1101});
    wait_digit(2);
    check("12af_d2", {a_if.out0, a_if.enable}, {7'b0010010, 4'b1011});
    wait_digit(3);
    check("12af_d3", {a_if.out0, a_if.enable}, {7'b1001111, 4'b0111});
    for (int n = 0; n < 12; n++) step();

    // leading-zero blanking with 0x0040
    load_a(16'h0040);
    wait_digit(0);
    check("0040_d0", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    wait_digit(1);
    check("0040_d1", {a_if.out0, a_if.enable}, {7'b1001100, 4'b1101});
    wait_digit(2);
    check("0040_d2", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});
    wait_digit(3);
    check("0040_d3", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});

    // all zero: only digit 0 lit
    load_a(16'h0000);
    wait_digit(1);
    check("0000_d1", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});
    wait_digit(0);
    check("0000_d0", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});

    // counter mode: 0xFFFE -> 0xFFFF -> 0x0000
    load_a(16'hFFFE);
    align_tick();
    a_if.mode = 1'b1;
    step();
    a_if.mode = 1'b0;
    wait_digit(0);
    check("inc_ffff_d0", {a_if.out0, a_if.enable}, {7'b0111000, 4'b1110});
    wait_digit(3);
    check("inc_ffff_d3", {a_if.out0, a_if.enable}, {7'b0111000, 4'b0111});
    align_tick();
    a_if.mode = 1'b1;
    step();
    a_if.mode = 1'b0;
    wait_digit(0);
    check("wrap_d0", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    wait_digit(1);
    check("wrap_d1", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});

    // load coinciding with a tick: the increment is lost
    align_tick();
    a_if.mode = 1'b1;
    load_a(16'h0100);
    a_if.mode = 1'b0;
    wait_digit(0);
    check("tickload_d0", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    wait_digit(2);
    check("tickload_d2", {a_if.out0, a_if.enable}, {7'b1001111, 4'b1011});

    // reset in the middle of digit 2 of 0x5555
    load_a(16'h5555);
    wait_digit(2);
    check("5555_d2", {a_if.out0, a_if.enable}, {7'b0100100, 4'b1011});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_a", {a_if.out0, a_if.enable}, {7'b1111111, 4'b1111});
    check("midrst_b", {b_if.out0, b_if.enable}, {7'b1111111, 2'b11});
    step();
    check("postrst_a", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    check("postrst_b", {7'h0, b_if.enable}, {7'h0, 2'b10});
    step();
    check("postrst_a2", {a_if.out0, a_if.enable}, {7'b0000001, 4'b1110});
    check("postrst_b2", {7'h0, b_if.enable}, {7'h0, 2'b01});
    for (int n = 0; n < 14; n++) step();

    // a few random loads checked by the per-cycle prediction
    for (int t = 0; t < 6; t++) begin
      load_a(16'($urandom_range(0, 16'hFFFF)));
      for (int n = 0; n < 13; n++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Time-multiplexed driver for an N-digit common-anode 7-segment display, the multi-digit successor of the single-digit counter/decoder on the board. Holds a 4·N-bit display register, either loaded from the datapath or self-incrementing as a hex counter, and scans it one digit at a time with optional leading-zero blanking. Sits at the top level between the datapath and the board display pins.

## Interface
- NUM_DIGITS, 4: digits driven; value width is 4·NUM_DIGITS.
- REFRESH_DIV, 100000: clk cycles each digit stays enabled; ≥1.
- TICK_DIV, 50000000: clk cycles between counter-mode increments; ≥1.
- BLANK_LEADING, 1: 1 = blank leading zero digits; 0 = show all digits.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4·NUM_DIGITS  data loaded into the display register.
- load  in  1  capture value this cycle.
- mode  in  1  0 = hold register, 1 = auto-increment on tick.
- out0  out  7  segments, active-low, bit6=a … bit0=g, registered.
- enable  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high, registered.

## Operation
- Display register disp (4·N bits), priority per cycle: rst → 0; load → value; mode=1 and tick → disp+1 (mod 2^(4N), all-F wraps to 0); else hold.
- Tick prescaler: counts 0..TICK_DIV-1, tick pulses one cycle at TICK_DIV-1 and wraps to 0; free-running regardless of mode. A tick coinciding with load is lost.
- Scan prescaler: counts 0..REFRESH_DIV-1; at terminal count, digit index advances (NUM_DIGITS-1 → 0). Digit 0 = least-significant nibble.
- Decode (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Blanking (BLANK_LEADING=1): digit i>0 is blank when nibble i and all higher nibbles are 0; blank digit → out0=1111111 and enable all-high. Digit 0 never blanked (0 shows "0").
- Non-blank digit i: enable = ~(1<<i), out0 = decode(nibble i of disp).

## Timing
- Reset values: out0=1111111, enable=all-high, disp=0, both prescalers=0, digit index=0.
- First cycle after rst deasserts: outputs present digit 0 of disp (one register stage).
- Output latency: out0/enable reflect digit index and disp of the previous cycle; a load at cycle t is visible on the current digit at t+2.
- Each digit enabled exactly REFRESH_DIV consecutive cycles; REFRESH_DIV=1 advances every cycle.
- rst mid-scan or mid-count: all state returns to reset values the next edge; no partial update.
- Prescaler widths $clog2 of the divisor (min 1); no overflow beyond terminal count.

## Structure
- Package seg7_pkg: SEG_BLANK (7'b1111111), the 16-entry active-low decode constant/function, digit-index width helper.
- One combinational sub-module, seg7_hex_decode (4-bit in, 7-bit out), instantiated once on the muxed nibble.
- Top holds disp register, two prescalers, digit index, blanking logic, output registers.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=3: reset, load 0x12AF → enable cycles 1110,1101,1011,0111 each 3 cycles; out0 = F(0111000), A(0001000), 2(0010010), 1(1001111).
- BLANK_LEADING=1, load 0x0040 → digits 2,3 show enable 1111/out0 1111111; digit 1 "4" (1001100); digit 0 "0" (0000001); load 0x0000 → only digit 0 lit.
- mode=1, TICK_DIV=2, load 0xFFFE → disp 0xFFFF after one tick, 0x0000 after next (wrap).
- load asserted in tick cycle with value 0x0100 → disp=0x0100, not 0x0101.
- Assert rst during digit 2 of scan with disp=0x5555 → next cycle out0=1111111, enable=1111; following cycle digit 0 shows "0".
- REFRESH_DIV=1, NUM_DIGITS=2 → enable alternates 10,01 every cycle after reset.
